rtc_hms: RTL
============

RTC_HMS -- requirements
Module: rtc_hms

Interface
REQ-001 SHALL have parameter CLK_FREQ_KHZ, default 100000, input clock frequency in kHz (integer >= 2).
REQ-002 SHALL have parameter ACC_W, default 32, width of the accumulated-ms counter (8..64).
REQ-003 SHALL have port clk  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port en  input  1  count enable; low freezes prescaler and all time fields.
REQ-006 SHALL have port load  input  1  single-cycle request to load time-of-day.
REQ-007 SHALL have ports ld_hour/ld_min/ld_sec/ld_ms  input  5/6/6/10  load values.
REQ-008 SHALL have ports hour/min/sec/ms  output  5/6/6/10  registered time-of-day.
REQ-009 SHALL have port ms_acc  output  ACC_W  ms since reset, free-running.
REQ-010 SHALL have ports tick_ms, tick_sec  output  1  one-cycle pulses on ms / second rollover.
REQ-011 SHALL have port load_err  output  1  one-cycle pulse when a load is rejected.
REQ-012 SHALL have ports al_hour/al_min/al_sec  input  5/6/6, al_arm  input  1, al_clr  input  1, al_pend  output  1 (alarm; see REQ-030).

Function
REQ-013 Prescaler SHALL count 0..CLK_FREQ_KHZ-1 while en=1; exactly CLK_FREQ_KHZ enabled cycles per ms, no extra cycle.
REQ-014 On prescaler terminal count: ms increments, ms_acc increments, tick_ms=1 the following cycle (1-cycle registered latency).
REQ-015 Cascade: ms 999->0 increments sec; sec 59->0 increments min; min 59->0 increments hour; hour 23->0.
REQ-016 tick_sec SHALL pulse in the same cycle as the tick_ms that reflects ms wrapping to 0.
REQ-017 ms_acc SHALL wrap 2^ACC_W-1 -> 0 silently; it is unaffected by load.
REQ-018 load with all fields in range (hour<24, min<60, sec<60, ms<1000) SHALL write fields next cycle and clear prescaler to 0.
REQ-019 load with any field out of range SHALL leave state unchanged and pulse load_err one cycle.
REQ-020 load coinciding with a prescaler terminal count SHALL win for time fields; ms_acc still increments; tick_ms still pulses.
REQ-021 load SHALL be accepted regardless of en.
REQ-022 en=0 SHALL hold prescaler, fields, ms_acc; no ticks generated.

Reset
REQ-023 rst=1 SHALL asynchronously clear prescaler, hour, min, sec, ms, ms_acc, tick_ms, tick_sec, load_err, al_pend to 0.
REQ-024 Reset assertion mid-count SHALL abort any pending tick; first ms after release needs CLK_FREQ_KHZ enabled cycles.

Configuration
REQ-025 Macro RTC_HMS_ALARM_EN SHALL gate the alarm comparator.
REQ-026 With macro defined: al_pend sets when al_arm=1 and a second rollover lands on hour:min:sec == al_hour:al_min:al_sec; stays set until al_clr=1.
REQ-027 al_clr and a new match in the same cycle SHALL leave al_pend set.
REQ-028 Alarm SHALL NOT trigger from a load landing on the match time.
REQ-029 Without macro: al_* inputs ignored, al_pend tied 0, no comparator logic.
REQ-030 Port list SHALL be identical in both builds.

Structure
REQ-031 Shared package rtc_pkg SHALL hold field widths and limits (MS_MAX=999, SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23) and a time-of-day struct typedef.
REQ-032 Sub-module rtc_prescaler (param DIV, en in, terminal-count pulse out) SHALL implement REQ-013.

Verification
REQ-033 CLK_FREQ_KHZ=4, en=1 from reset: tick_ms every 4 cycles; ms=1 after first 4 enabled cycles.
REQ-034 load 23:59:59.998, run 2 ms -> fields 00:00:00.000, tick_sec one pulse, ms_acc +2.
REQ-035 load ld_min=60 -> load_err one pulse, fields unchanged.
REQ-036 en low 10 cycles mid-ms -> tick_ms delayed exactly 10 cycles.
REQ-037 RTC_HMS_ALARM_EN, al_arm=1, alarm 00:00:02, run from reset -> al_pend at 2 s rollover; al_clr clears; undefined build -> al_pend stays 0.
REQ-038 ACC_W=8, run 256 ms -> ms_acc wraps to 0; rst pulse mid-ms -> all outputs 0 immediately.

Source files
------------

// File: rtl/rtc_pkg.sv
// Shared widths, limits and time-of-day type for the rtc_hms real-time clock.
// Includes the range check and the one-millisecond advance used by the top.
package rtc_pkg;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;
    localparam int MS_W   = 10;

    localparam int MS_MAX   = 999;
    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;

    typedef struct packed {
        logic [HOUR_W-1:0] hour;
        logic [MIN_W-1:0]  min;
        logic [SEC_W-1:0]  sec;
        logic [MS_W-1:0]   ms;
    } tod_t;

    function automatic logic tod_valid(input tod_t t);
        return (t.hour <= HOUR_W'(HOUR_MAX)) &&
               (t.min  <= MIN_W'(MIN_MAX))   &&
               (t.sec  <= SEC_W'(SEC_MAX))   &&
               (t.ms   <= MS_W'(MS_MAX));
    endfunction

    // Advance by one millisecond, carrying through to a 24-hour wrap.
    function automatic tod_t tod_inc(input tod_t t);
        tod_t n;
        n = t;
        if (t.ms == MS_W'(MS_MAX)) begin
            n.ms = '0;
            if (t.sec == SEC_W'(SEC_MAX)) begin
                n.sec = '0;
                if (t.min == MIN_W'(MIN_MAX)) begin
                    n.min = '0;
                    if (t.hour == HOUR_W'(HOUR_MAX)) begin
                        n.hour = '0;
                    end else begin
                        n.hour = t.hour + 1'b1;
                    end
                end else begin
                    n.min = t.min + 1'b1;
                end
            end else begin
                n.sec = t.sec + 1'b1;
            end
        end else begin
            n.ms = t.ms + 1'b1;
        end
        return n;
    endfunction

endpackage

// File: rtl/rtc_prescaler.sv
// Divides the enabled clock by DIV; tc_o is high on the last enabled cycle.
// A clear restarts the count at 0 and takes priority over counting.
module rtc_prescaler #(
    parameter int DIV = 100000
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic clr_i,
    output logic tc_o
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] TERM = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tc_o = en_i && (cnt_q == TERM);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || tc_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rtc_hms.sv
// Hour:min:sec.ms real-time clock with free-running ms accumulator and load.
// Optional alarm comparator is built only when RTC_HMS_ALARM_EN is defined.
module rtc_hms
    import rtc_pkg::*;
#(
    parameter int CLK_FREQ_KHZ = 100000,
    parameter int ACC_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              load,
    input  logic [HOUR_W-1:0] ld_hour,
    input  logic [MIN_W-1:0]  ld_min,
    input  logic [SEC_W-1:0]  ld_sec,
    input  logic [MS_W-1:0]   ld_ms,
    output logic [HOUR_W-1:0] hour,
    output logic [MIN_W-1:0]  min,
    output logic [SEC_W-1:0]  sec,
    output logic [MS_W-1:0]   ms,
    output logic [ACC_W-1:0]  ms_acc,
    output logic              tick_ms,
    output logic              tick_sec,
    output logic              load_err,
    input  logic [HOUR_W-1:0] al_hour,
    input  logic [MIN_W-1:0]  al_min,
    input  logic [SEC_W-1:0]  al_sec,
    input  logic              al_arm,
    input  logic              al_clr,
    output logic              al_pend
);

    tod_t             tod_q, tod_d, tod_nx, ld_tod;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic             tick_ms_q, tick_ms_d;
    logic             tick_sec_q, tick_sec_d;
    logic             err_q, err_d;
    logic             tc;
    logic             ld_ok;

    assign ld_tod = '{hour: ld_hour, min: ld_min, sec: ld_sec, ms: ld_ms};
    assign ld_ok  = load && tod_valid(ld_tod);
    assign tod_nx = tod_inc(tod_q);

    rtc_prescaler #(
        .DIV (CLK_FREQ_KHZ)
    ) u_presc (
        .clk   (clk),
        .rst   (rst),
        .en_i  (en),
        .clr_i (ld_ok),
        .tc_o  (tc)
    );

    // A valid load overrides the cascade, but the elapsed ms still counts.
    always_comb begin
        tod_d      = tod_q;
        acc_d      = acc_q;
        tick_ms_d  = tc;
        tick_sec_d = 1'b0;
        err_d      = load && !ld_ok;
        if (tc) begin
            acc_d = acc_q + 1'b1;
        end
        if (ld_ok) begin
            tod_d = ld_tod;
        end else if (tc) begin
            tod_d      = tod_nx;
            tick_sec_d = (tod_q.ms == MS_W'(MS_MAX));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tod_q      <= '0;
            acc_q      <= '0;
            tick_ms_q  <= 1'b0;
            tick_sec_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            tod_q      <= tod_d;
            acc_q      <= acc_d;
            tick_ms_q  <= tick_ms_d;
            tick_sec_q <= tick_sec_d;
            err_q      <= err_d;
        end
    end

    assign hour     = tod_q.hour;
    assign min      = tod_q.min;
    assign sec      = tod_q.sec;
    assign ms       = tod_q.ms;
    assign ms_acc   = acc_q;
    assign tick_ms  = tick_ms_q;
    assign tick_sec = tick_sec_q;
    assign load_err = err_q;

`ifdef RTC_HMS_ALARM_EN
    logic al_hit;
    logic al_pend_q, al_pend_d;

    // Only a counted second rollover can hit; loads never do.
    assign al_hit = tick_sec_d && al_arm &&
                    (tod_nx.hour == al_hour) &&
                    (tod_nx.min  == al_min)  &&
                    (tod_nx.sec  == al_sec);

    always_comb begin
        al_pend_d = al_pend_q;
        if (al_hit) begin
            al_pend_d = 1'b1;
        end else if (al_clr) begin
            al_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            al_pend_q <= 1'b0;
        end else begin
            al_pend_q <= al_pend_d;
        end
    end

    assign al_pend = al_pend_q;
`else
    logic unused_al;
    assign unused_al = ^{al_hour, al_min, al_sec, al_arm, al_clr};
    assign al_pend   = 1'b0;
`endif

endmodule
